pool_core_mc: RTL and testbench
===============================

Name: pool_core_mc

Overview:
- Multi-channel, mode-selectable pooling core; successor to the single-channel max-only pooling core.
- Reduces one WIN_H x WIN_W window per channel, for CH_NUM channels in parallel, to one value per channel.
- Reduction is either max or rounded average, selected per input beat.
- Sits between the window/line-buffer generator and the next layer's input FIFO; full valid/ready handshake with backpressure.

Parameters:
- DATA_WIDTH, 8, signed fixed-point sample width. Format unchanged by the block.
- WIN_H, 3, window rows (>=1).
- WIN_W, 3, window columns (>=1). N = WIN_H*WIN_W, N >= 2.
- CH_NUM, 4, parallel channels.
- RECIP_SHIFT, 16, fractional bits of the averaging reciprocal.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- din_vld  in  1  input beat valid
- din_rdy  out  1  core can accept a beat
- din_mode  in  1  0 = max, 1 = average; sampled with the beat
- din  in  CH_NUM*N*DATA_WIDTH  signed windows, packed [CH_NUM-1:0][N-1:0][DATA_WIDTH-1:0], element index = row*WIN_W+col
- dout_vld  out  1  output beat valid
- dout_rdy  in  1  downstream accepts
- dout  out  CH_NUM*DATA_WIDTH  signed results, packed [CH_NUM-1:0][DATA_WIDTH-1:0]

Behaviour:
- Reset (async, active-high): all pipeline valid bits 0, all data and mode registers 0; dout_vld=0, dout=0; din_rdy=1 once reset is released.
- Pipeline enable: en = !dout_vld || dout_rdy. The whole pipeline advances only when en=1. din_rdy = en.
- A beat is accepted when din_vld && din_rdy.
- Tree:
  - STAGE_NUM = clog2(N) registered binary-tree stages.
  - Stage s holds ceil(N/2^(s+1)) nodes.
  - An odd leftover element passes through unchanged to the next stage.
  - Each node performs max (mode 0) or signed add (mode 1), selected by the mode bit carried alongside its data.
  - Node width SUM_W = DATA_WIDTH + clog2(N). Inputs are sign-extended, so max results are exact.
- Scale stage (1 registered stage):
  - Mode 0: dout = tree result truncated to DATA_WIDTH (lossless).
  - Mode 1: p = sum * RECIP, with RECIP = round(2^RECIP_SHIFT / N) as an unsigned constant. Then r = (p + 2^(RECIP_SHIFT-1)) >>> RECIP_SHIFT, an arithmetic shift (round half up).
  - r saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Latency: L = STAGE_NUM + 1 cycles from acceptance to dout_vld with no stalls. For 3x3, L = 5. Throughput is 1 beat/cycle.
- Valid and mode travel in an L-deep delay line that shares en.
- Backpressure:
  - While dout_vld && !dout_rdy: dout and dout_vld stay stable and no internal register changes.
  - No beat is lost or duplicated.
- Simultaneous accept and output on the same cycle is legal and required for full throughput.
- Mode may change on every beat. Each beat's result uses its own sampled mode.
- Reset mid-operation: all in-flight beats are discarded; no output appears after reset deasserts until a new beat is accepted.
- Bubbles (din_vld=0) propagate as invalid stages and are not compressed.

Decomposition:
- Package pool_pkg holds:
  - pool_mode_t (POOL_MAX=0, POOL_AVG=1)
  - functions clog2, stage_nodes(N,s) and recip(N,shift)
  - the derived SUM_W formula
- Sub-module pool_lane: one channel's reduction tree plus scale stage. Inputs are en, the mode delay line and the window; output is the result. It is instantiated CH_NUM times.
- The top level owns the handshake, en, and the valid/mode delay line.

Test Plan (defaults unless stated):
- Max mode: ch0 window = 1..9, ch1 all -128, ch2 = {-5,-3,-9,...,-4} with max -3, ch3 a single 127 at element 8 -> after 5 cycles dout = {127, -3, -128, 9}, dout_vld for exactly 1 cycle.
- Average mode: ch0 = 1..9 (sum 45) -> 5; ch1 all -128 -> -128; ch2 all 127 -> 127; ch3 = {1,0,...,0} -> 0 (1*7282+32768 >> 16 = 0).
- Back-to-back 20 beats alternating mode with random data and dout_rdy=1 -> 20 outputs in consecutive cycles, each matching a reference model using its own mode.
- Backpressure: stream 10 beats while dout_rdy is held low for cycles 3-8 -> din_rdy=0 while stalled, dout stable, all 10 results in order, none dropped or duplicated.
- Reset asserted mid-stream with 3 beats in flight -> dout_vld=0 and dout=0 immediately (async); no stale output after release; next beat yields its correct result at L=5.
- WIN_H=2, WIN_W=2, CH_NUM=1 build: average of {3,4,4,4} -> 4 (15/4 = 3.75, rounded); latency 3.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel pooling core.
package pool_pkg;

    typedef enum logic [0:0] {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_t;

    // Smallest k with 2**k >= n.
    function automatic int clog2(input int n);
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) >= n) begin
                return k;
            end
        end
        return 31;
    endfunction

    // Node count of tree stage s: ceil(n / 2**(s+1)). s = -1 yields n itself,
    // which lets stage 0 treat the raw window as its "previous stage".
    function automatic int stage_nodes(input int n, input int s);
        return (n + (1 << (s + 1)) - 1) >> (s + 1);
    endfunction

    // round(2**shift / n) as an unsigned integer.
    function automatic int recip(input int n, input int shift);
        return ((1 << shift) + n / 2) / n;
    endfunction

    // Tree node width: enough headroom to hold the sum of n samples.
    function automatic int sum_width(input int data_width, input int n);
        return data_width + clog2(n);
    endfunction

endpackage

// File: rtl/pool_core_mc_lane.sv
// One channel of the pooling core: registered binary reduction tree followed
// by a registered scale/saturate stage. Mode for each level arrives from the
// shared delay line owned by the top level.
module pool_lane
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int WIN_H       = 3,
    parameter int WIN_W       = 3,
    parameter int RECIP_SHIFT = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  en,
    input  logic [clog2(WIN_H*WIN_W):0]           mode_line,
    input  logic [WIN_H*WIN_W*DATA_WIDTH-1:0]     win,
    output logic [DATA_WIDTH-1:0]                 result
);

    localparam int N         = WIN_H * WIN_W;
    localparam int STAGE_NUM = clog2(N);
    localparam int SUM_W     = sum_width(DATA_WIDTH, N);
    // Product width: sum width plus the reciprocal (unsigned, so one extra
    // bit for the sign) plus one bit of margin for the rounding add.
    localparam int P_W       = SUM_W + RECIP_SHIFT + 2;

    localparam logic signed [P_W-1:0] RECIP_P = P_W'(recip(N, RECIP_SHIFT));
    localparam logic signed [P_W-1:0] ROUND_P = P_W'(2 ** (RECIP_SHIFT - 1));
    localparam logic signed [P_W-1:0] SAT_MAX = P_W'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [P_W-1:0] SAT_MIN = P_W'(-(2 ** (DATA_WIDTH - 1)));

    genvar gs, gi;

    for (gs = 0; gs < STAGE_NUM; gs++) begin : g_stage
        localparam int IN_N  = stage_nodes(N, gs - 1);
        localparam int OUT_N = stage_nodes(N, gs);

        logic signed [SUM_W-1:0] in_val    [IN_N];
        logic signed [SUM_W-1:0] node_next [OUT_N];
        logic signed [SUM_W-1:0] node_reg  [OUT_N];

        if (gs == 0) begin : g_src
            // Sign-extend raw samples so max comparisons stay exact.
            for (gi = 0; gi < N; gi++) begin : g_elem
                assign in_val[gi] = {{(SUM_W - DATA_WIDTH){win[gi*DATA_WIDTH + DATA_WIDTH - 1]}},
                                     win[gi*DATA_WIDTH +: DATA_WIDTH]};
            end
        end else begin : g_src
            for (gi = 0; gi < IN_N; gi++) begin : g_elem
                assign in_val[gi] = g_stage[gs-1].node_reg[gi];
            end
        end

        for (gi = 0; gi < OUT_N; gi++) begin : g_node
            if (2 * gi + 1 < IN_N) begin : g_pair
                assign node_next[gi] = (mode_line[gs] == POOL_AVG)
                                     ? in_val[2*gi] + in_val[2*gi+1]
                                     : ((in_val[2*gi] > in_val[2*gi+1]) ? in_val[2*gi] : in_val[2*gi+1]);
            end else begin : g_odd
                // Leftover element of an odd-sized level passes straight through.
                assign node_next[gi] = in_val[2*gi];
            end
        end

        // Register this tree level; frozen while the pipeline is stalled.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < OUT_N; i++) begin
                    node_reg[i] <= '0;
                end
            end else if (en) begin
                for (int i = 0; i < OUT_N; i++) begin
                    node_reg[i] <= node_next[i];
                end
            end
        end
    end

    logic signed [SUM_W-1:0]  tree_sum;
    logic signed [P_W-1:0]    prod;
    logic signed [P_W-1:0]    shifted;
    logic [DATA_WIDTH-1:0]    result_next;
    logic [DATA_WIDTH-1:0]    result_reg;

    assign tree_sum = g_stage[STAGE_NUM-1].node_reg[0];

    // Max passes through losslessly; average multiplies by the reciprocal,
    // rounds half up with an arithmetic shift and saturates.
    always_comb begin
        prod    = P_W'(tree_sum) * RECIP_P;
        shifted = (prod + ROUND_P) >>> RECIP_SHIFT;
        if (mode_line[STAGE_NUM] == POOL_AVG) begin
            if (shifted > SAT_MAX) begin
                result_next = SAT_MAX[DATA_WIDTH-1:0];
            end else if (shifted < SAT_MIN) begin
                result_next = SAT_MIN[DATA_WIDTH-1:0];
            end else begin
                result_next = shifted[DATA_WIDTH-1:0];
            end
        end else begin
            result_next = tree_sum[DATA_WIDTH-1:0];
        end
    end

    // Output register of the lane.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_reg <= '0;
        end else if (en) begin
            result_reg <= result_next;
        end
    end

    assign result = result_reg;

endmodule

// File: rtl/pool_core_mc.sv
// Multi-channel max/average pooling core. Owns the handshake, the global
// pipeline enable and the valid/mode delay line; channels are pool_lane copies.
module pool_core_mc
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int WIN_H       = 3,
    parameter int WIN_W       = 3,
    parameter int CH_NUM      = 4,
    parameter int RECIP_SHIFT = 16
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     din_vld,
    output logic                                     din_rdy,
    input  logic                                     din_mode,
    input  logic [CH_NUM*WIN_H*WIN_W*DATA_WIDTH-1:0] din,
    output logic                                     dout_vld,
    input  logic                                     dout_rdy,
    output logic [CH_NUM*DATA_WIDTH-1:0]             dout
);

    localparam int N         = WIN_H * WIN_W;
    localparam int STAGE_NUM = clog2(N);
    localparam int L         = STAGE_NUM + 1;

    logic                 en;
    logic [L-1:0]         vld_reg;
    logic [STAGE_NUM-1:0] mode_reg;
    logic [STAGE_NUM:0]   mode_line;

    // The whole pipeline moves together; it only holds when a valid result
    // is waiting and downstream refuses it.
    assign en        = !vld_reg[L-1] || dout_rdy;
    assign din_rdy   = en;
    assign dout_vld  = vld_reg[L-1];
    assign mode_line = {mode_reg, din_mode};

    // Valid and mode shift alongside the data, gated by the same enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_reg  <= '0;
            mode_reg <= '0;
        end else if (en) begin
            vld_reg  <= {vld_reg[L-2:0], din_vld && din_rdy};
            mode_reg[0] <= din_mode;
            for (int i = 1; i < STAGE_NUM; i++) begin
                mode_reg[i] <= mode_reg[i-1];
            end
        end
    end

    genvar gi;
    for (gi = 0; gi < CH_NUM; gi++) begin : g_lane
        pool_lane #(
            .DATA_WIDTH  (DATA_WIDTH),
            .WIN_H       (WIN_H),
            .WIN_W       (WIN_W),
            .RECIP_SHIFT (RECIP_SHIFT)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .en        (en),
            .mode_line (mode_line),
            .win       (din[gi*N*DATA_WIDTH +: N*DATA_WIDTH]),
            .result    (dout[gi*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_pool_core_mc.sv
// Directed bench for pool_core_mc: a default 3x3x4 instance plus a 2x2x1 build.
module tb_pool_core_mc;

    localparam int DW    = 8;
    localparam int CH    = 4;
    localparam int NW    = 9;
    localparam int DIN_W = CH * NW * DW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic             din_vld  = 1'b0;
    logic             din_rdy;
    logic             din_mode = 1'b0;
    logic [DIN_W-1:0] din      = '0;
    logic             dout_vld;
    logic             dout_rdy = 1'b1;
    logic [CH*DW-1:0] dout;

    logic             din2_vld  = 1'b0;
    logic             din2_rdy;
    logic             din2_mode = 1'b0;
    logic [31:0]      din2      = '0;
    logic             dout2_vld;
    logic [7:0]       dout2;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    pool_core_mc #(
        .DATA_WIDTH(8), .WIN_H(3), .WIN_W(3), .CH_NUM(4), .RECIP_SHIFT(16)
    ) u_dut (
        .clk(clk), .reset(reset),
        .din_vld(din_vld), .din_rdy(din_rdy), .din_mode(din_mode), .din(din),
        .dout_vld(dout_vld), .dout_rdy(dout_rdy), .dout(dout)
    );

    pool_core_mc #(
        .DATA_WIDTH(8), .WIN_H(2), .WIN_W(2), .CH_NUM(1), .RECIP_SHIFT(16)
    ) u_dut2 (
        .clk(clk), .reset(reset),
        .din_vld(din2_vld), .din_rdy(din2_rdy), .din_mode(din2_mode), .din(din2),
        .dout_vld(dout2_vld), .dout_rdy(1'b1), .dout(dout2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: per channel max, or (sum*7282 + 2^15) >>> 16 saturated.
    function automatic logic [31:0] model(input logic [DIN_W-1:0] w, input logic mode);
        logic [31:0] res;
        int mx, sum, v, r;
        res = '0;
        for (int c = 0; c < CH; c++) begin
            mx  = -129;
            sum = 0;
            for (int e = 0; e < NW; e++) begin
                v = int'($signed(w[(c*NW+e)*DW +: DW]));
                sum += v;
                if (v > mx) mx = v;
            end
            if (mode) begin
                r = (sum * 7282 + 32768) >>> 16;
                if (r > 127)  r = 127;
                if (r < -128) r = -128;
            end else begin
                r = mx;
            end
            res[c*DW +: DW] = r[7:0];
        end
        return res;
    endfunction

    // Single beat on the 3x3 instance: valid exactly at cycle 5, once.
    task automatic one_beat(input string tag, input logic [31:0] exp);
        @(negedge clk);
        din_vld = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            din_vld = 1'b0;
            chk({tag, "_vld"}, 32'(dout_vld), 32'(i == 5));
            if (i == 5) chk({tag, "_data"}, dout, exp);
        end
    endtask

    // Single beat on the 2x2 instance: valid exactly at cycle 3.
    task automatic one_beat2(input string tag, input logic [31:0] exp);
        @(negedge clk);
        din2_vld = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            din2_vld = 1'b0;
            chk({tag, "_vld"}, 32'(dout2_vld), 32'(i == 3));
            if (i == 3) chk({tag, "_data"}, 32'(dout2), exp);
        end
    endtask

    // Random stream with alternating mode; dout_rdy low for cycles lo..hi.
    task automatic stream(input string tag, input int nbeats, input int lo, input int hi,
                          input int max_cycles, output int first_c, output int last_c);
        int sent, got;
        bit need_new, held;
        logic [31:0] held_val;
        logic [DIN_W-1:0] cur;
        logic cur_mode;
        sent = 0; got = 0; need_new = 1'b1; held = 1'b0;
        held_val = '0; cur = '0; cur_mode = 1'b0;
        first_c = -1; last_c = -1;
        exp_q.delete();
        for (int c = 0; c < max_cycles && got < nbeats; c++) begin
            @(negedge clk);
            if (held) begin
                chk({tag, "_hold_vld"}, 32'(dout_vld), 1);
                chk({tag, "_hold_data"}, dout, held_val);
            end
            dout_rdy = !(c >= lo && c <= hi);
            if (sent < nbeats) begin
                if (need_new) begin
                    for (int w = 0; w < CH*NW; w++) cur[w*DW +: DW] = DW'($urandom);
                    cur_mode = sent[0];
                    need_new = 1'b0;
                end
                din = cur; din_mode = cur_mode; din_vld = 1'b1;
            end else begin
                din_vld = 1'b0;
            end
            #1;
            held = 1'b0;
            if (dout_vld) begin
                if (dout_rdy) begin
                    chk({tag, "_expected_avail"}, 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) chk({tag, "_data"}, dout, exp_q.pop_front());
                    got++;
                    if (first_c < 0) first_c = c;
                    last_c = c;
                end else begin
                    held = 1'b1;
                    held_val = dout;
                    chk({tag, "_stall_rdy"}, 32'(din_rdy), 0);
                end
            end
            if (din_vld && din_rdy) begin
                exp_q.push_back(model(cur, cur_mode));
                sent++;
                need_new = 1'b1;
            end
        end
        din_vld = 1'b0;
        dout_rdy = 1'b1;
        chk({tag, "_out_count"}, got, nbeats);
        chk({tag, "_in_count"}, sent, nbeats);
    endtask

    initial begin
        int fc, lc, vld_seen;
        int ch2v [9];
        ch2v = '{-5, -3, -9, -7, -6, -8, -10, -20, -4};

        // Reset state
        #1;
        chk("rst_vld", 32'(dout_vld), 0);
        chk("rst_dout", dout, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_rdy", 32'(din_rdy), 1);
        chk("rst_rdy2", 32'(din2_rdy), 1);

        // Max mode: expect {127, -3, -128, 9}
        for (int e = 0; e < NW; e++) begin
            din[(0*NW+e)*DW +: DW] = DW'(e + 1);
            din[(1*NW+e)*DW +: DW] = 8'h80;
            din[(2*NW+e)*DW +: DW] = DW'(ch2v[e]);
            din[(3*NW+e)*DW +: DW] = (e == 8) ? 8'h7F : 8'h00;
        end
        din_mode = 1'b0;
        one_beat("max", 32'h7FFD8009);

        // Reset with 3 beats in flight: outputs clear at once, nothing stale
        din_mode = 1'b1;
        @(negedge clk);
        din_vld = 1'b1;
        repeat (3) @(negedge clk);
        din_vld = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_rst_vld", 32'(dout_vld), 0);
        chk("mid_rst_dout", dout, 0);
        @(negedge clk);
        reset = 1'b0;
        vld_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (dout_vld) vld_seen++;
        end
        chk("mid_rst_stale", vld_seen, 0);
        din_mode = 1'b0;
        one_beat("post_rst", 32'h7FFD8009);

        // Average mode: expect {0, 127, -128, 5}
        for (int e = 0; e < NW; e++) begin
            din[(0*NW+e)*DW +: DW] = DW'(e + 1);
            din[(1*NW+e)*DW +: DW] = 8'h80;
            din[(2*NW+e)*DW +: DW] = 8'h7F;
            din[(3*NW+e)*DW +: DW] = (e == 0) ? 8'h01 : 8'h00;
        end
        din_mode = 1'b1;
        one_beat("avg", 32'h007F8005);

        // Back-to-back, alternating mode, full throughput
        stream("b2b", 20, -1, -1, 60, fc, lc);
        chk("b2b_consecutive", lc - fc, 19);

        // Backpressure window
        stream("bp", 10, 3, 8, 80, fc, lc);

        // 2x2 single-channel build: avg {3,4,4,4} -> 4, avg {-1,-2,-2,-2} -> -2
        din2 = {8'd4, 8'd4, 8'd4, 8'd3};
        din2_mode = 1'b1;
        one_beat2("w2_avg", 32'h00000004);
        din2 = {8'hFE, 8'hFE, 8'hFE, 8'hFF};
        one_beat2("w2_avg_neg", 32'h000000FE);
        din2 = {8'hFD, 8'h02, 8'hF9, 8'hFF};
        din2_mode = 1'b0;
        one_beat2("w2_max", 32'h00000002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
